div_sched: RTL and testbench
============================

# div_sched

Programmable clock-enable divider scheduler for the divider family. Owns the period counter and the divide ratio in a single `clk` domain, and sequences ratio changes so they take effect only at a period boundary. Emits a one-cycle `clk_en` strobe per period and a near-50% `clk_div` level for downstream logic. Replaces ad-hoc fixed dividers such as divide-by-5 wherever the ratio must change at run time.

## Interface
- `CNT_W`, 8, width of ratio and counter.
- `DEF_DIV`, 5, ratio loaded at reset; legal range 1..2^CNT_W-1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; level-sensitive.
- `req_valid`  in  1  new-ratio request.
- `req_div`  in  CNT_W  requested ratio N.
- `req_ready`  out  1  request slot free.
- `busy`  out  1  state is not IDLE.
- `clk_en`  out  1  one-cycle strobe on the last cycle of each period.
- `clk_div`  out  1  divided level.
- `cur_div`  out  CNT_W  ratio currently in effect.
- `err`  out  1  one-cycle pulse when a ratio-0 request is accepted.

## Operation
- Reset values:
  - state = IDLE; `cnt` = 0; `cur_div` = `DEF_DIV`.
  - Pending slot empty.
  - `err` = 0; `clk_en` = 0; `clk_div` = 0; `busy` = 0; `req_ready` = 1.
  - Requests presented while `rst` = 1 are discarded.
- States:
  - **IDLE:** counter held at 0, outputs low. `enable` = 1 moves to RUN.
  - **RUN:** `cnt` counts 0..N-1 and wraps. `enable` = 0 moves to DRAIN.
  - **DRAIN:** counting continues until `cnt` = N-1, then IDLE. `enable` = 1 during DRAIN returns to RUN with no gap in counting.
- Output decode (combinational from registers only, no input-to-output paths):
  - H = ceil(N/2).
  - In RUN/DRAIN, `clk_div` = (`cnt` < H) and `clk_en` = (`cnt` = N-1).
  - In IDLE, both are 0.
- Handshake:
  - A transfer occurs when `req_valid` and `req_ready` are both 1.
  - `req_ready` = pending slot empty.
  - In IDLE, an accepted ratio loads `cur_div` at that edge; the slot stays empty.
  - In RUN/DRAIN, an accepted ratio is written to the slot and `req_ready` drops.
  - At the next edge where `cnt` = N-1, `cur_div` takes the pending ratio, `cnt` goes to 0, and the slot clears.
  - If acceptance and `cnt` = N-1 happen in the same cycle, the new ratio applies at that same edge.
- Ratio 0:
  - The request is accepted but `cur_div` and the pending slot are unchanged.
  - `err` pulses high for the cycle after the accepting edge.
- Ratio 1: `clk_en` and `clk_div` are both 1 on every RUN cycle.
- A pending ratio is applied at the boundary that ends DRAIN, so the next start uses it.
- `rst` mid-period aborts immediately to the reset values; the pending ratio is lost.

## Timing
- `enable` sampled 1 at edge t: first RUN cycle (`cnt` = 0, `clk_div` = 1) follows edge t.
- First `clk_en` occurs N-1 cycles after that first RUN cycle.
- `clk_en` period is exactly `cur_div` cycles; no short or long period at a ratio change.
- `req_ready` recovers 1 cycle after the applying boundary.
- `err` latency: 1 cycle.

## Configuration
- Macro: `DIV_SCHED_PHASE_EN`.
- Defined:
  - Adds output `phase`, CNT_W bits, equal to `cnt`: 0 in IDLE, counting 0..N-1 otherwise.
  - Adds output `wrap_cnt`, 16 bits: increments on each `clk_en`, wraps at 65535 to 0, reset 0.
- Undefined: neither port exists; the logic is removed.

## Structure
- Package `div_sched_pkg`:
  - state typedef (IDLE, RUN, DRAIN);
  - `CNT_W` default and `DEF_DIV` default as constants;
  - H computation as a function.
- Sub-module `div_sched_cnt`:
  - counter, wrap detect and output decode;
  - inputs: `cur_div` and a run qualifier;
  - outputs: `cnt`, `at_end`, `clk_en`, `clk_div`.
- Top level keeps the FSM, pending slot and handshake.

## Test plan
- **Reset default:** release `rst`, raise `enable`.
  - `clk_div` shows 3 high / 2 low.
  - `clk_en` pulses every 5 cycles, first at the 5th RUN cycle.
  - `cur_div` = 5.
- **Mid-period change:** request 8 at `cnt` = 1 with N = 5.
  - `req_ready` drops.
  - The current period still lasts 5 cycles.
  - Then 4 high / 4 low periods of 8; `req_ready` returns to 1.
- **Same-cycle change:** request 3 in the cycle where `cnt` = 4 with N = 5.
  - The next period is 3 cycles (2 high / 1 low).
  - No extra period at 5.
- **Stop and resume:** `enable` low at `cnt` = 2 with N = 5.
  - `clk_en` fires at `cnt` = 4, then IDLE with `busy` = 0.
  - Re-enabling during DRAIN gives continuous 5-cycle periods.
- **Illegal and degenerate ratios:**
  - Request 0: `err` pulses 1 cycle, `cur_div` unchanged.
  - Request 1: `clk_en` = `clk_div` = 1 on every cycle.
- **Reset abort:** `rst` asserted while a ratio is pending.
  - All outputs return to reset values; `cur_div` = 5.
  - With `DIV_SCHED_PHASE_EN` defined, `phase` = 0 and `wrap_cnt` = 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and constants for the div_sched divider scheduler.
//   state_t      - scheduler state (IDLE, RUN, DRAIN)
//   CNT_W_DEF    - default ratio/counter width
//   DEF_DIV_DEF  - default ratio loaded at reset
//   half_ceil()  - high-phase length ceil(n/2) of a period of n cycles
package div_sched_pkg;

    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned DEF_DIV_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ceil(n/2) written so it cannot overflow for n = 2^32-1
    function automatic int unsigned half_ceil(input int unsigned n);
        return (n / 2) + (n & 32'd1);
    endfunction

endpackage

// File: rtl/div_sched_cnt.sv
// div_sched_cnt: period counter, end-of-period detect and output decode.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   run       - 1 while the scheduler is in RUN or DRAIN
//   cur_div   - ratio N currently in effect (1..2^CNT_W-1)
//   cnt       - position within the period, 0..N-1 (0 when not running)
//   at_end    - cnt is at N-1 while running (period boundary next edge)
//   clk_en    - one-cycle strobe on the last cycle of each period
//   clk_div   - divided level, high for the first ceil(N/2) cycles
module div_sched_cnt
    import div_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] cur_div,
    output logic [CNT_W-1:0] cnt,
    output logic             at_end,
    output logic             clk_en,
    output logic             clk_div
);

    logic [CNT_W-1:0] half;

    // Output decode from registers only; nothing here sees module inputs
    // other than the registered run qualifier and ratio.
    always_comb begin
        half    = CNT_W'(half_ceil(32'(cur_div)));
        at_end  = run && (cnt == (cur_div - CNT_W'(1)));
        clk_en  = at_end;
        clk_div = run && (cnt < half);
    end

    // Counter: held at 0 when idle, wraps to 0 at each boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/div_sched.sv
// div_sched: programmable clock-enable divider scheduler.
// Ratio changes are queued in a one-entry slot and applied only at a period
// boundary, so every clk_en period is exactly the ratio in effect.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   enable               - run request (level)
//   req_valid/req_div    - new-ratio request; req_ready = slot free
//   busy                 - scheduler not IDLE
//   clk_en               - strobe on the last cycle of each period
//   clk_div              - divided level, ceil(N/2) high
//   cur_div              - ratio in effect
//   err                  - one-cycle pulse after a ratio-0 request is accepted
// Optional (macro DIV_SCHED_PHASE_EN):
//   phase                - current counter value
//   wrap_cnt             - 16-bit count of clk_en strobes
module div_sched
    import div_sched_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_div,
    output logic             req_ready,
    output logic             busy,
    output logic             clk_en,
    output logic             clk_div,
    output logic [CNT_W-1:0] cur_div,
    output logic             err
`ifdef DIV_SCHED_PHASE_EN
    ,
    output logic [CNT_W-1:0] phase,
    output logic [15:0]      wrap_cnt
`endif
);

    state_t           state;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cnt;
    logic             at_end;
    logic             run;
    logic             accept;
    logic             req_zero;

    assign run       = (state != ST_IDLE);
    assign busy      = run;
    assign req_ready = !pend_valid;
    assign accept    = req_valid && req_ready;
    assign req_zero  = (req_div == '0);

    div_sched_cnt #(
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cur_div (cur_div),
        .cnt     (cnt),
        .at_end  (at_end),
        .clk_en  (clk_en),
        .clk_div (clk_div)
    );

    // FSM, pending slot and ratio update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_div    <= CNT_W'(DEF_DIV);
            pend_valid <= 1'b0;
            pend_div   <= '0;
            err        <= 1'b0;
        end else begin
            err <= accept && req_zero;

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Re-enable resumes without restarting the period.
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (at_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (!run) begin
                // No period in progress: a ratio takes effect at once.
                if (accept && !req_zero) begin
                    cur_div <= req_div;
                end
            end else if (at_end) begin
                // Boundary: pending ratio wins; a request landing on this
                // cycle (slot necessarily empty) applies here too.
                if (pend_valid) begin
                    cur_div <= pend_div;
                end else if (accept && !req_zero) begin
                    cur_div <= req_div;
                end
                pend_valid <= 1'b0;
            end else if (accept && !req_zero) begin
                pend_valid <= 1'b1;
                pend_div   <= req_div;
            end
        end
    end

`ifdef DIV_SCHED_PHASE_EN
    assign phase = cnt;

    // Strobe counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_cnt <= '0;
        end else if (clk_en) begin
            wrap_cnt <= wrap_cnt + 16'd1;
        end
    end
`else
    logic cnt_unused;
    assign cnt_unused = ^cnt;
`endif

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: self-checking bench for div_sched. A behavioural model
// (period position, ratio, queue of pending ratios) predicts every output
// each cycle; directed steps cover the documented scenarios, then random
// stimulus follows.
module tb_div_sched;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       req_valid;
    logic [7:0] req_div;
    logic       req_ready;
    logic       busy;
    logic       clk_en;
    logic       clk_div;
    logic [7:0] cur_div;
    logic       err;
`ifdef DIV_SCHED_PHASE_EN
    logic [7:0]  phase;
    logic [15:0] wrap_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model
    bit m_active;
    bit m_stop;
    int m_cnt;
    int m_div;
    int m_pend[$];
    bit m_err;
    int m_wrap;

    div_sched dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .busy      (busy),
        .clk_en    (clk_en),
        .clk_div   (clk_div),
        .cur_div   (cur_div),
        .err       (err)
`ifdef DIV_SCHED_PHASE_EN
        ,
        .phase     (phase),
        .wrap_cnt  (wrap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_stop   = 1'b0;
        m_cnt    = 0;
        m_div    = 5;
        m_pend.delete();
        m_err    = 1'b0;
        m_wrap   = 0;
    endtask

    // Advance the model by one clock edge using the inputs of that cycle.
    task automatic model_step(input bit en, input bit rv, input int rd, input bit r, input bit strobe);
        bit acc;
        bit last;
        if (r) begin
            model_reset();
            return;
        end
        acc = rv && (m_pend.size() == 0);
        if (strobe) m_wrap = (m_wrap + 1) % 65536;
        if (!m_active) begin
            m_cnt = 0;
            if (acc && rd != 0) m_div = rd;
            if (en) begin
                m_active = 1'b1;
                m_stop   = 1'b0;
            end
        end else begin
            last = (m_cnt == m_div - 1);
            if (last) begin
                m_cnt = 0;
                if (m_pend.size() != 0) m_div = m_pend.pop_front();
                else if (acc && rd != 0) m_div = rd;
            end else begin
                m_cnt = m_cnt + 1;
                if (acc && rd != 0) m_pend.push_back(rd);
            end
            if (m_stop) begin
                if (en) m_stop = 1'b0;
                else if (last) m_active = 1'b0;
            end else if (!en) begin
                m_stop = 1'b1;
            end
        end
        m_err = acc && (rd == 0);
    endtask

    // One clock cycle: drive inputs, compare all outputs, clock, update model.
    task automatic cyc(input bit en, input bit rv, input int rd, input bit r);
        bit exp_en;
        bit exp_div;
        enable    = en;
        req_valid = rv;
        req_div   = 8'(rd);
        rst       = r;
        exp_en  = m_active && (m_cnt == m_div - 1);
        exp_div = m_active && (m_cnt < (m_div + 1) / 2);
        chk("clk_en", 32'(clk_en), 32'(exp_en));
        chk("clk_div", 32'(clk_div), 32'(exp_div));
        chk("busy", 32'(busy), 32'(m_active));
        chk("req_ready", 32'(req_ready), 32'(m_pend.size() == 0));
        chk("cur_div", 32'(cur_div), 32'(m_div));
        chk("err", 32'(err), 32'(m_err));
`ifdef DIV_SCHED_PHASE_EN
        chk("phase", 32'(phase), 32'(m_cnt));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
`endif
        @(posedge clk);
        model_step(en, rv, rd, r, exp_en);
        #1;
    endtask

    task automatic run_until_cnt(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 600) begin
            cyc(1, 0, 0, 0);
            k++;
        end
        if (k >= 600) chk("align_timeout", 32'(k), 32'(0));
    endtask

    // Cycles from the current one up to and including the next clk_en.
    task automatic cycles_to_en(output int n);
        n = 1;
        while (clk_en !== 1'b1 && n < 600) begin
            cyc(1, 0, 0, 0);
            n++;
        end
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        enable    = 1'b0;
        req_valid = 1'b0;
        req_div   = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        // Reset default
        chk("rst_cur_div", 32'(cur_div), 32'd5);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clk_div", 32'(clk_div), 32'd0);
        cyc(0, 1, 7, 1);
        chk("rst_discard_req", 32'(cur_div), 32'd5);
        cyc(1, 0, 0, 0);
        chk("first_run_clk_div", 32'(clk_div), 32'd1);
        repeat (4) cyc(1, 0, 0, 0);
        chk("first_clk_en", 32'(clk_en), 32'd1);

        // Mid-period change 5 -> 8
        run_until_cnt(1);
        cyc(1, 1, 8, 0);
        chk("mid_ready_drop", 32'(req_ready), 32'd0);
        chk("mid_cur_hold", 32'(cur_div), 32'd5);
        cycles_to_en(n);
        chk("mid_old_period_rest", 32'(n), 32'd3);
        cyc(1, 0, 0, 0);
        chk("mid_cur_new", 32'(cur_div), 32'd8);
        chk("mid_ready_back", 32'(req_ready), 32'd1);
        cycles_to_en(n);
        chk("mid_new_period", 32'(n), 32'd8);

        // Same-cycle change: back to 5 on a boundary, then 3 at cnt=4
        cyc(1, 1, 5, 0);
        chk("same_cur_5", 32'(cur_div), 32'd5);
        run_until_cnt(4);
        cyc(1, 1, 3, 0);
        chk("same_cur_3", 32'(cur_div), 32'd3);
        chk("same_ready", 32'(req_ready), 32'd1);
        cycles_to_en(n);
        chk("same_period_3", 32'(n), 32'd3);

        // Stop and resume at N = 5
        cyc(1, 1, 5, 0);
        run_until_cnt(2);
        cyc(0, 0, 0, 0);
        chk("drain_busy", 32'(busy), 32'd1);
        cyc(0, 0, 0, 0);
        chk("drain_clk_en", 32'(clk_en), 32'd1);
        cyc(0, 0, 0, 0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_clk_div", 32'(clk_div), 32'd0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        run_until_cnt(2);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("resume_clk_en", 32'(clk_en), 32'd1);
        cyc(1, 0, 0, 0);
        cycles_to_en(n);
        chk("resume_period", 32'(n), 32'd5);

        // Ratio 0
        cyc(1, 1, 0, 0);
        chk("zero_err", 32'(err), 32'd1);
        chk("zero_cur", 32'(cur_div), 32'd5);
        chk("zero_ready", 32'(req_ready), 32'd1);
        cyc(1, 0, 0, 0);
        chk("zero_err_clear", 32'(err), 32'd0);

        // Ratio 1
        cyc(1, 1, 1, 0);
        n = 0;
        while (m_pend.size() != 0 && n < 600) begin
            cyc(1, 0, 0, 0);
            n++;
        end
        if (n >= 600) chk("ratio1_timeout", 32'(n), 32'd0);
        chk("ratio1_cur", 32'(cur_div), 32'd1);
        repeat (6) begin
            chk("ratio1_clk_en", 32'(clk_en), 32'd1);
            chk("ratio1_clk_div", 32'(clk_div), 32'd1);
            cyc(1, 0, 0, 0);
        end

        // Reset abort with a pending ratio
        cyc(1, 1, 5, 0);
        chk("abort_cur_5", 32'(cur_div), 32'd5);
        run_until_cnt(1);
        cyc(1, 1, 9, 0);
        chk("abort_pending", 32'(req_ready), 32'd0);
        cyc(1, 0, 0, 1);
        chk("abort_cur", 32'(cur_div), 32'd5);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_clk_en", 32'(clk_en), 32'd0);
        chk("abort_clk_div", 32'(clk_div), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
`ifdef DIV_SCHED_PHASE_EN
        chk("abort_phase", 32'(phase), 32'd0);
        chk("abort_wrap", 32'(wrap_cnt), 32'd0);
`endif

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit rv;
            bit r;
            int rd;
            en = ($urandom_range(0, 9) != 0);
            rv = ($urandom_range(0, 6) == 0);
            r  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) rd = int'($urandom_range(0, 40));
            else rd = int'($urandom_range(0, 9));
            cyc(en, rv, rd, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
